ff_input_cond: RTL and testbench

//  Parametrised player-input conditioner for the foodfight board tops.
//  - Synchronises and debounces NUM_IN raw push-buttons.
//  - Drives the game's active-low switch vector.
//  - Replaces the fixed button/auto_*_n gating in each board top.
//  - Optional attract-mode autoplay sequencer: coin, start, periodic throw.
//  - Sits between board pins and ff_top.sw.

---
 rtl/ff_input_pkg.sv | 42 ++++
 rtl/ff_input_cond_if.sv | 35 +++
 rtl/ff_debounce.sv | 65 ++++++
 rtl/ff_input_cond.sv | 168 ++++++++++++++++
 tb/tb_ff_input_cond.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ff_input_pkg.sv
// ----------------------------------------------------------------------------
// ff_input_pkg
// Shared definitions for the foodfight player-input conditioner.
//  - Autoplay state encoding (3 bits, IDLE..PLAY = 0..5).
//  - Default timing constants for a 12 MHz system clock.
//  - Small elaboration-time helpers for sizing counters.
// ----------------------------------------------------------------------------
package ff_input_pkg;

    localparam int AP_STATE_W = 3;

    typedef enum logic [AP_STATE_W-1:0] {
        AP_IDLE  = 3'd0,
        AP_WAIT  = 3'd1,
        AP_COIN  = 3'd2,
        AP_GAP1  = 3'd3,
        AP_START = 3'd4,
        AP_PLAY  = 3'd5
    } ap_state_t;

    // Defaults for a 12 MHz clock.
    localparam int DEF_NUM_IN       = 8;
    localparam int DEF_DEB_COUNT    = 12000;     // 1 ms
    localparam int DEF_COIN_IDX     = 0;
    localparam int DEF_START_IDX    = 1;
    localparam int DEF_THROW_IDX    = 2;
    localparam int DEF_AUTO_DELAY   = 24000000;  // 2 s
    localparam int DEF_PULSE_LEN    = 1200000;   // 100 ms
    localparam int DEF_THROW_PERIOD = 6000000;   // 500 ms

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits needed to hold 0..n-1; never less than one bit.
    function automatic int width_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ff_input_cond_if.sv
// ----------------------------------------------------------------------------
// ff_input_cond_if
// Bundle between the board pins / bench and the input conditioner.
//  btn_i        raw buttons, 1 = pressed, asynchronous to the clock
//  auto_en      run-time autoplay enable (level)
//  sw_n_o       conditioned switches, 0 = pressed
//  pressed_o    one-cycle strobe on each debounced press
//  auto_state_o current autoplay state encoding
// Modports: master drives the buttons, slave is the conditioner.
// ----------------------------------------------------------------------------
interface ff_input_cond_if #(
    parameter int NUM_IN = 8
);
    logic [NUM_IN-1:0] btn_i;
    logic              auto_en;
    logic [NUM_IN-1:0] sw_n_o;
    logic [NUM_IN-1:0] pressed_o;
    logic [2:0]        auto_state_o;

    modport master (
        output btn_i,
        output auto_en,
        input  sw_n_o,
        input  pressed_o,
        input  auto_state_o
    );

    modport slave (
        input  btn_i,
        input  auto_en,
        output sw_n_o,
        output pressed_o,
        output auto_state_o
    );
endinterface

// File: rtl/ff_debounce.sv
// ----------------------------------------------------------------------------
// ff_debounce
// One button channel: two-flop synchroniser, stability counter, accepted
// level register and a one-cycle press strobe.
// Ports:
//  clk12m    in  system clock
//  reset     in  asynchronous active-high reset
//  btn_raw   in  raw button, 1 = pressed
//  stable_o  out debounced level (registered)
//  press_o   out one-cycle strobe when the debounced level rises
// Parameter DEB_COUNT: consecutive cycles the synchronised input must differ
// from the accepted level before the change is taken.
// ----------------------------------------------------------------------------
module ff_debounce
    import ff_input_pkg::*;
#(
    parameter int DEB_COUNT = DEF_DEB_COUNT
) (
    input  logic clk12m,
    input  logic reset,
    input  logic btn_raw,
    output logic stable_o,
    output logic press_o
);

    localparam int CNT_W = width_for(DEB_COUNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_COUNT - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             stable_reg;
    logic             press_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk12m or posedge reset) begin
        if (reset) begin
            sync1_reg  <= 1'b0;
            sync2_reg  <= 1'b0;
            stable_reg <= 1'b0;
            press_reg  <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            sync1_reg <= btn_raw;
            sync2_reg <= sync1_reg;
            press_reg <= 1'b0;
            if (sync2_reg != stable_reg) begin
                if (cnt_reg == CNT_LAST) begin
                    stable_reg <= sync2_reg;
                    cnt_reg    <= '0;
                    // Only a newly accepted press strobes, not a release.
                    press_reg  <= sync2_reg;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end else begin
                // Any bounce back to the accepted level restarts the count.
                cnt_reg <= '0;
            end
        end
    end

    assign stable_o = stable_reg;
    assign press_o  = press_reg;

endmodule

// File: rtl/ff_input_cond.sv
// ----------------------------------------------------------------------------
// ff_input_cond
// Player-input conditioner for the foodfight board tops. Debounces NUM_IN
// raw buttons and drives the game's active-low switch vector; optionally
// runs an attract-mode autoplay sequence (coin, start, periodic throw).
// Ports:
//  clk12m  in  system clock, all logic on the rising edge
//  reset   in  asynchronous active-high reset
//  bus     ff_input_cond_if.slave: btn_i, auto_en in; sw_n_o, pressed_o,
//          auto_state_o out
// Configuration macro FF_AUTOPLAY_EN:
//  defined   - autoplay FSM and shared timer are built.
//  undefined - pure debouncer; auto_en ignored, auto_state_o reads 0.
// ----------------------------------------------------------------------------
module ff_input_cond
    import ff_input_pkg::*;
#(
    parameter int NUM_IN       = DEF_NUM_IN,
    parameter int DEB_COUNT    = DEF_DEB_COUNT,
    parameter int COIN_IDX     = DEF_COIN_IDX,
    parameter int START_IDX    = DEF_START_IDX,
    parameter int THROW_IDX    = DEF_THROW_IDX,
    parameter int AUTO_DELAY   = DEF_AUTO_DELAY,
    parameter int PULSE_LEN    = DEF_PULSE_LEN,
    parameter int THROW_PERIOD = DEF_THROW_PERIOD
) (
    input logic           clk12m,
    input logic           reset,
    ff_input_cond_if.slave bus
);

    logic [NUM_IN-1:0] stable;
    logic [NUM_IN-1:0] pressed;
    logic [NUM_IN-1:0] auto_mask;

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_deb
            ff_debounce #(
                .DEB_COUNT (DEB_COUNT)
            ) u_deb (
                .clk12m   (clk12m),
                .reset    (reset),
                .btn_raw  (bus.btn_i[gi]),
                .stable_o (stable[gi]),
                .press_o  (pressed[gi])
            );
        end
    endgenerate

`ifdef FF_AUTOPLAY_EN
    // One timer serves every phase, so it is sized for the longest one.
    localparam int TIMER_W = width_for(max3(AUTO_DELAY, PULSE_LEN, THROW_PERIOD));
    localparam logic [TIMER_W-1:0] DELAY_LAST  = TIMER_W'(AUTO_DELAY - 1);
    localparam logic [TIMER_W-1:0] PULSE_LAST  = TIMER_W'(PULSE_LEN - 1);
    localparam logic [TIMER_W-1:0] PERIOD_LAST = TIMER_W'(THROW_PERIOD - 1);

    localparam logic [NUM_IN-1:0] COIN_MASK  = NUM_IN'(1) << COIN_IDX;
    localparam logic [NUM_IN-1:0] START_MASK = NUM_IN'(1) << START_IDX;
    localparam logic [NUM_IN-1:0] THROW_MASK = NUM_IN'(1) << THROW_IDX;

    ap_state_t          state_reg;
    logic [TIMER_W-1:0] timer_reg;
    logic [NUM_IN-1:0]  mask_reg;
    logic               disarmed_reg;

    // Masks are updated on the same edge as the state change so sw_n_o
    // follows the state with no extra delay.
    always_ff @(posedge clk12m or posedge reset) begin
        if (reset) begin
            state_reg    <= AP_IDLE;
            timer_reg    <= '0;
            mask_reg     <= '0;
            disarmed_reg <= 1'b0;
        end else if (!bus.auto_en) begin
            // Dropping the enable also re-arms, and beats a coincident press.
            state_reg    <= AP_IDLE;
            timer_reg    <= '0;
            mask_reg     <= '0;
            disarmed_reg <= 1'b0;
        end else if ((state_reg != AP_IDLE) && (|pressed)) begin
            // A real player took over: stop and stay off until re-enabled.
            state_reg    <= AP_IDLE;
            timer_reg    <= '0;
            mask_reg     <= '0;
            disarmed_reg <= 1'b1;
        end else begin
            case (state_reg)
                AP_IDLE: begin
                    mask_reg <= '0;
                    if (!disarmed_reg) begin
                        state_reg <= AP_WAIT;
                        timer_reg <= '0;
                    end
                end
                AP_WAIT: begin
                    if (timer_reg == DELAY_LAST) begin
                        state_reg <= AP_COIN;
                        timer_reg <= '0;
                        mask_reg  <= COIN_MASK;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                AP_COIN: begin
                    if (timer_reg == PULSE_LAST) begin
                        state_reg <= AP_GAP1;
                        timer_reg <= '0;
                        mask_reg  <= '0;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                AP_GAP1: begin
                    if (timer_reg == PULSE_LAST) begin
                        state_reg <= AP_START;
                        timer_reg <= '0;
                        mask_reg  <= START_MASK;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                AP_START: begin
                    if (timer_reg == PULSE_LAST) begin
                        state_reg <= AP_PLAY;
                        timer_reg <= '0;
                        mask_reg  <= THROW_MASK;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                AP_PLAY: begin
                    // Throw is held while the *next* timer value is inside
                    // the first PULSE_LEN cycles of the window.
                    if (timer_reg == PERIOD_LAST) begin
                        timer_reg <= '0;
                        mask_reg  <= THROW_MASK;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                        mask_reg  <= (timer_reg < PULSE_LAST) ? THROW_MASK : '0;
                    end
                end
                default: begin
                    state_reg <= AP_IDLE;
                    timer_reg <= '0;
                    mask_reg  <= '0;
                end
            endcase
        end
    end

    assign auto_mask        = mask_reg;
    assign bus.auto_state_o = state_reg;
`else
    assign auto_mask        = '0;
    assign bus.auto_state_o = AP_IDLE;

    // Autoplay inputs and parameters have no function in this build.
    logic unused_autoplay;
    assign unused_autoplay = ^{bus.auto_en, COIN_IDX, START_IDX, THROW_IDX,
                               AUTO_DELAY, PULSE_LEN, THROW_PERIOD};
`endif

    // Both operands are registers, so the outputs are glitch-free and have
    // no combinational path from the pins.
    assign bus.sw_n_o    = ~(stable | auto_mask);
    assign bus.pressed_o = pressed;

endmodule

// File: tb/tb_ff_input_cond.sv
// ----------------------------------------------------------------------------
// tb_ff_input_cond
// Directed bench for ff_input_cond with NUM_IN=4, DEB_COUNT=4, AUTO_DELAY=5,
// PULSE_LEN=3, THROW_PERIOD=8. Autoplay scenarios run when FF_AUTOPLAY_EN is
// defined; otherwise the disabled-autoplay scenario runs.
// ----------------------------------------------------------------------------
module tb_ff_input_cond;

    localparam int NUM_IN       = 4;
    localparam int DEB_COUNT    = 4;
    localparam int AUTO_DELAY   = 5;
    localparam int PULSE_LEN    = 3;
    localparam int THROW_PERIOD = 8;

    logic clk12m = 1'b0;
    logic reset  = 1'b1;

    always #5 clk12m = ~clk12m;

    ff_input_cond_if #(.NUM_IN(NUM_IN)) bus ();

    ff_input_cond #(
        .NUM_IN       (NUM_IN),
        .DEB_COUNT    (DEB_COUNT),
        .COIN_IDX     (0),
        .START_IDX    (1),
        .THROW_IDX    (2),
        .AUTO_DELAY   (AUTO_DELAY),
        .PULSE_LEN    (PULSE_LEN),
        .THROW_PERIOD (THROW_PERIOD)
    ) dut (
        .clk12m (clk12m),
        .reset  (reset),
        .bus    (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Advance one clock; inputs are driven and outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk12m);
        #1;
    endtask

    task automatic test_reset();
        bus.btn_i   = '0;
        bus.auto_en = 1'b0;
        reset       = 1'b1;
        repeat (3) tick();
        tests_run++;
        if (bus.sw_n_o !== 4'b1111) begin
            tests_failed++;
            $display("FAIL reset_sw_n: got %b expected 1111", bus.sw_n_o);
        end
        tests_run++;
        if (bus.pressed_o !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_pressed: got %b expected 0000", bus.pressed_o);
        end
        tests_run++;
        if (bus.auto_state_o !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d expected 0", bus.auto_state_o);
        end
        reset = 1'b0;
        tick();
        $display("[TB] test_reset done");
    endtask

    // btn_i[3] held: accepted exactly 2 + DEB_COUNT = 6 cycles later.
    task automatic test_debounce_press();
        logic [3:0] exp_sw;
        logic [3:0] exp_pr;
        bus.btn_i = 4'b1000;
        for (int t = 1; t <= 7; t++) begin
            tick();
            exp_sw = (t >= 6) ? 4'b0111 : 4'b1111;
            exp_pr = (t == 6) ? 4'b1000 : 4'b0000;
            tests_run++;
            if (bus.sw_n_o !== exp_sw) begin
                tests_failed++;
                $display("FAIL press_sw_n t=%0d: got %b expected %b", t, bus.sw_n_o, exp_sw);
            end
            tests_run++;
            if (bus.pressed_o !== exp_pr) begin
                tests_failed++;
                $display("FAIL press_strobe t=%0d: got %b expected %b", t, bus.pressed_o, exp_pr);
            end
        end
        // Release: same latency, no strobe.
        bus.btn_i = 4'b0000;
        for (int t = 1; t <= 6; t++) begin
            tick();
            exp_sw = (t >= 6) ? 4'b1111 : 4'b0111;
            tests_run++;
            if (bus.sw_n_o !== exp_sw) begin
                tests_failed++;
                $display("FAIL release_sw_n t=%0d: got %b expected %b", t, bus.sw_n_o, exp_sw);
            end
            tests_run++;
            if (bus.pressed_o !== 4'b0000) begin
                tests_failed++;
                $display("FAIL release_strobe t=%0d: got %b expected 0000", t, bus.pressed_o);
            end
        end
        $display("[TB] test_debounce_press done");
    endtask

    // A 3-cycle pulse is one cycle short of acceptance.
    task automatic test_glitch();
        bus.btn_i = 4'b0010;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (t == 3) bus.btn_i = 4'b0000;
            tests_run++;
            if (bus.sw_n_o !== 4'b1111) begin
                tests_failed++;
                $display("FAIL glitch_sw_n t=%0d: got %b expected 1111", t, bus.sw_n_o);
            end
            tests_run++;
            if (bus.pressed_o !== 4'b0000) begin
                tests_failed++;
                $display("FAIL glitch_strobe t=%0d: got %b expected 0000", t, bus.pressed_o);
            end
        end
        $display("[TB] test_glitch done");
    endtask

`ifdef FF_AUTOPLAY_EN
    // WAIT t=1..5, COIN t=6..8, GAP1 t=9..11, START t=12..14, PLAY from 15
    // with throw held for 3 of every 8 cycles starting at t=15.
    task automatic test_autoplay();
        logic [2:0] exp_st;
        logic [3:0] exp_sw;
        bus.auto_en = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (t <= 5) begin
                exp_st = 3'd1; exp_sw = 4'b1111;
            end else if (t <= 8) begin
                exp_st = 3'd2; exp_sw = 4'b1110;
            end else if (t <= 11) begin
                exp_st = 3'd3; exp_sw = 4'b1111;
            end else if (t <= 14) begin
                exp_st = 3'd4; exp_sw = 4'b1101;
            end else begin
                exp_st = 3'd5;
                exp_sw = (((t - 15) % 8) < 3) ? 4'b1011 : 4'b1111;
            end
            tests_run++;
            if (bus.auto_state_o !== exp_st) begin
                tests_failed++;
                $display("FAIL auto_state t=%0d: got %0d expected %0d", t, bus.auto_state_o, exp_st);
            end
            tests_run++;
            if (bus.sw_n_o !== exp_sw) begin
                tests_failed++;
                $display("FAIL auto_sw_n t=%0d: got %b expected %b", t, bus.sw_n_o, exp_sw);
            end
        end
        $display("[TB] test_autoplay done");
    endtask

    task automatic test_autoplay_abort();
        bus.btn_i = 4'b1000;
        repeat (6) tick();
        tests_run++;
        if (bus.pressed_o !== 4'b1000) begin
            tests_failed++;
            $display("FAIL abort_strobe: got %b expected 1000", bus.pressed_o);
        end
        tests_run++;
        if (bus.auto_state_o !== 3'd5) begin
            tests_failed++;
            $display("FAIL abort_state_at_strobe: got %0d expected 5", bus.auto_state_o);
        end
        tick();
        tests_run++;
        if (bus.auto_state_o !== 3'd0) begin
            tests_failed++;
            $display("FAIL abort_state_after: got %0d expected 0", bus.auto_state_o);
        end
        tests_run++;
        if (bus.sw_n_o !== 4'b0111) begin
            tests_failed++;
            $display("FAIL abort_sw_n: got %b expected 0111", bus.sw_n_o);
        end
        for (int t = 1; t <= 12; t++) begin
            tick();
            tests_run++;
            if (bus.auto_state_o !== 3'd0) begin
                tests_failed++;
                $display("FAIL disarmed_state t=%0d: got %0d expected 0", t, bus.auto_state_o);
            end
        end
        bus.btn_i = 4'b0000;
        repeat (8) tick();
        tests_run++;
        if (bus.sw_n_o !== 4'b1111 || bus.auto_state_o !== 3'd0) begin
            tests_failed++;
            $display("FAIL disarmed_idle: got sw_n=%b state=%0d expected 1111/0",
                     bus.sw_n_o, bus.auto_state_o);
        end
        bus.auto_en = 1'b0;
        tick();
        tests_run++;
        if (bus.auto_state_o !== 3'd0) begin
            tests_failed++;
            $display("FAIL rearm_low: got %0d expected 0", bus.auto_state_o);
        end
        bus.auto_en = 1'b1;
        tick();
        tests_run++;
        if (bus.auto_state_o !== 3'd1) begin
            tests_failed++;
            $display("FAIL rearm_wait: got %0d expected 1", bus.auto_state_o);
        end
        bus.auto_en = 1'b0;
        tick();
        tests_run++;
        if (bus.auto_state_o !== 3'd0 || bus.sw_n_o !== 4'b1111) begin
            tests_failed++;
            $display("FAIL enable_drop: got state=%0d sw_n=%b expected 0/1111",
                     bus.auto_state_o, bus.sw_n_o);
        end
        $display("[TB] test_autoplay_abort done");
    endtask
`else
    task automatic test_no_autoplay();
        bus.auto_en = 1'b1;
        for (int t = 1; t <= 100; t++) begin
            tick();
            tests_run++;
            if (bus.sw_n_o !== 4'b1111 || bus.auto_state_o !== 3'd0) begin
                tests_failed++;
                $display("FAIL no_auto t=%0d: got sw_n=%b state=%0d expected 1111/0",
                         t, bus.sw_n_o, bus.auto_state_o);
            end
        end
        bus.auto_en = 1'b0;
        tick();
        $display("[TB] test_no_autoplay done");
    endtask
`endif

    // Reset raised between edges must clear outputs with no clock edge.
    task automatic test_reset_midrun();
        bus.btn_i = 4'b0001;
        repeat (6) tick();
        tests_run++;
        if (bus.sw_n_o !== 4'b1110) begin
            tests_failed++;
            $display("FAIL midrun_pre_sw_n: got %b expected 1110", bus.sw_n_o);
        end
        tests_run++;
        if (bus.pressed_o !== 4'b0001) begin
            tests_failed++;
            $display("FAIL midrun_pre_strobe: got %b expected 0001", bus.pressed_o);
        end
        #3;
        reset = 1'b1;
        #1;
        tests_run++;
        if (bus.sw_n_o !== 4'b1111) begin
            tests_failed++;
            $display("FAIL midrun_sw_n: got %b expected 1111", bus.sw_n_o);
        end
        tests_run++;
        if (bus.pressed_o !== 4'b0000) begin
            tests_failed++;
            $display("FAIL midrun_strobe: got %b expected 0000", bus.pressed_o);
        end
        tests_run++;
        if (bus.auto_state_o !== 3'd0) begin
            tests_failed++;
            $display("FAIL midrun_state: got %0d expected 0", bus.auto_state_o);
        end
        bus.btn_i = 4'b0000;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        $display("[TB] test_reset_midrun done");
    endtask

    initial begin
        test_reset();
        test_debounce_press();
        test_glitch();
`ifdef FF_AUTOPLAY_EN
        test_autoplay();
        test_autoplay_abort();
`else
        test_no_autoplay();
`endif
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
